pixel_fifo: RTL and testbench

PIXEL_FIFO -- requirements
Module: pixel_fifo

---
 rtl/pixel_fifo.sv | 118 +++++++++++
 tb/tb_pixel_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fifo.sv
// Pixel FIFO between frame-memory reader and VGA DAC: holds the raster until
// HIGH_WM pixels are buffered, then streams one pixel per visible slot.
// Optional macro PIXEL_FIFO_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module pixel_fifo #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 10,
  parameter int HIGH_WM = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              blank,
  output logic              hold,
  output logic [DATA_W-1:0] rgb,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underrun
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] START_LVL = (ADDR_W+1)'(HIGH_WM);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   level_reg, level_next;
  logic [DATA_W-1:0] rgb_reg;
  logic              hold_reg, overflow_reg, underrun_reg;
  logic              rd, wr_ok, rd_ok, underrun_next, overflow_next;

  assign full     = (level_reg == DEPTH);
  assign hold     = hold_reg;
  assign rgb      = rgb_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign underrun = underrun_reg;

  always_comb begin
    state_next    = state_reg;
    level_next    = level_reg;
    rd            = (state_reg == RUN) && !blank;
    wr_ok         = wr_en && !full;
    rd_ok         = rd && (level_reg != '0);
    underrun_next = rd && (level_reg == '0);
    overflow_next = wr_en && full;

    if (wr_ok && !rd_ok)
      level_next = level_reg + (ADDR_W+1)'(1);
    else if (rd_ok && !wr_ok)
      level_next = level_reg - (ADDR_W+1)'(1);

    case (state_reg)
      FILL: if (level_reg >= START_LVL) state_next = RUN;
      RUN:  if (underrun_next)          state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // hold is registered alongside the state so it always equals (state == FILL)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FILL;
      hold_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      hold_reg  <= (state_next == FILL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      rgb_reg      <= '0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      level_reg    <= level_next;
      rgb_reg      <= rd_ok ? mem[rd_ptr_reg] : '0;
      overflow_reg <= overflow_next;
      underrun_reg <= underrun_next;
    end
  end

  // Storage is left uninitialised; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underrun_cnt_reg <= '0;
    else if (underrun_next && (underrun_cnt_reg != 16'hFFFF))
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
  end

  assign underrun_cnt = underrun_cnt_reg;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// Testbench for pixel_fifo: queue-based reference model compared every cycle,
// directed watermark/underrun/overflow/wrap/reset scenarios, then random traffic.
module tb_pixel_fifo;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;
  localparam int HIGH_WM = 512;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic              blank = 1'b1;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full, hold, overflow, underrun;
  logic [DATA_W-1:0] rgb;
  logic [ADDR_W:0]   level;
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
  int                exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  pixel_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HIGH_WM(HIGH_WM)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .blank    (blank),
    .hold     (hold),
    .rgb      (rgb),
    .level    (level),
    .overflow (overflow),
    .underrun (underrun)
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pixel queue plus a "display running" flag.
  logic [DATA_W-1:0] q[$];
  bit                running = 1'b0;
  bit                model_valid = 1'b0;
  logic [DATA_W-1:0] exp_rgb = '0;
  bit                exp_overflow = 1'b0;
  bit                exp_underrun = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic w, input logic [DATA_W-1:0] d, input logic b);
    int n;
    bit was_full, rd_req;
    n        = q.size();
    was_full = (n == DEPTH);
    rd_req   = running && !b;
    exp_overflow = w && was_full;
    exp_underrun = rd_req && (n == 0);
    exp_rgb      = '0;
    if (rd_req && n > 0) exp_rgb = q.pop_front();
    if (w && !was_full) q.push_back(d);
    if (!running && n >= HIGH_WM) running = 1'b1;
    else if (running && exp_underrun) running = 1'b0;
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
    if (exp_underrun && exp_cnt < 65535) exp_cnt++;
`endif
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("rgb", rgb, exp_rgb);
      chk("hold", hold, !running);
      chk("level", level, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("overflow", overflow, exp_overflow);
      chk("underrun", underrun, exp_underrun);
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
      chk("underrun_cnt", underrun_cnt, exp_cnt);
`endif
    end
  end

  // One clock: drive inputs, advance the model at the edge, return at negedge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic b);
    wr_en   = w;
    wr_data = d;
    blank   = b;
    @(posedge clk);
    model_update(w, d, b);
    @(negedge clk);
  endtask

  // Reset asserted between edges so its effect must appear without a clock.
  task automatic do_reset();
    wr_en = 1'b0;
    blank = 1'b1;
    #2 reset = 1'b1;
    #1;
    q.delete();
    running      = 1'b0;
    exp_rgb      = '0;
    exp_overflow = 1'b0;
    exp_underrun = 1'b0;
    model_valid  = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_hold", hold, 1);
    chk("rst_rgb", rgb, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underrun", underrun, 0);
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
    exp_cnt = 0;
    chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  int wp_tab[8] = '{90, 30, 70, 10, 95, 50, 60, 20};
  int bp_tab[8] = '{70, 40, 50, 20, 90, 60, 30, 50};

  initial begin
    @(negedge clk);
    do_reset();
    $display("scenario reset level=%0d hold=%0b", level, hold);

    // Watermark: 511 pixels keep the raster held, the 512th releases it.
    for (int i = 1; i <= 511; i++) step(1'b1, 12'(i), 1'b0);
    chk("wm511_hold", hold, 1);
    chk("wm511_rgb", rgb, 0);
    chk("wm511_level", level, 511);
    step(1'b1, 12'(512), 1'b0);
    chk("wm512_hold", hold, 1);
    chk("wm512_level", level, 512);
    step(1'b0, '0, 1'b1);
    chk("run_hold", hold, 0);
    $display("scenario watermark level=%0d hold=%0b", level, hold);

    // Drain in order, one cycle after each visible slot.
    for (int i = 1; i <= 512; i++) begin
      step(1'b0, '0, 1'b0);
      if (i == 1) chk("first_px", rgb, 12'h001);
    end
    chk("last_px", rgb, 12'h200);
    chk("drained_level", level, 0);
    chk("drained_hold", hold, 0);
    $display("scenario drain level=%0d rgb=%0h", level, rgb);

    // Underrun: read requested with nothing buffered.
    step(1'b0, '0, 1'b0);
    chk("underrun_pulse", underrun, 1);
    chk("underrun_hold", hold, 1);
    chk("underrun_rgb", rgb, 0);
`ifdef PIXEL_FIFO_UNDERRUN_CNT_EN
    chk("underrun_cnt_one", underrun_cnt, 1);
`endif
    step(1'b0, '0, 1'b1);
    chk("underrun_clear", underrun, 0);
    $display("scenario underrun hold=%0b", hold);

    // Fill to capacity, then one write too many.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 12'($urandom), 1'b1);
    chk("cap_full", full, 1);
    chk("cap_level", level, 1024);
    step(1'b1, 12'hABC, 1'b1);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_level", level, 1024);
    step(1'b0, '0, 1'b1);
    chk("ovf_clear", overflow, 0);
    $display("scenario overflow level=%0d full=%0b", level, full);

    // Drain to 300 (read pointer wraps), then balanced read/write.
    repeat (724) step(1'b0, '0, 1'b0);
    chk("lvl300", level, 300);
    repeat (100) step(1'b1, 12'($urandom), 1'b0);
    chk("balanced_level", level, 300);
    chk("balanced_hold", hold, 0);
    $display("scenario balanced level=%0d", level);

    // Reset mid-stream, then refill to the watermark.
    repeat (400) step(1'b1, 12'($urandom), 1'b1);
    chk("lvl700", level, 700);
    chk("lvl700_hold", hold, 0);
    do_reset();
    for (int i = 0; i < HIGH_WM; i++) step(1'b1, 12'($urandom), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("refill_hold", hold, 0);
    $display("scenario midreset_refill level=%0d hold=%0b", level, hold);

    // Random traffic with phase-varying write and blanking densities.
    for (int i = 0; i < 4000; i++) begin
      int ph;
      ph = i / 500;
      if ($urandom_range(0, 799) == 0)
        do_reset();
      else
        step($urandom_range(0, 99) < wp_tab[ph], 12'($urandom),
             $urandom_range(0, 99) < bp_tab[ph]);
      if (i % 500 == 499)
        $display("scenario random_phase%0d level=%0d hold=%0b", ph, level, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
